fifo_rr_wr_arbiter: RTL and testbench
=====================================

Name: fifo_rr_wr_arbiter

Overview:
Round-robin write arbiter that lets NREQ requesters share the write port of one synchronous FIFO. Each requester uses a valid/ready handshake with packet locking: a requester holds the grant from its first beat until its last beat. The block keeps its own occupancy count from the writes it issues and the reads it observes, and never issues a write the FIFO cannot accept. It sits between the requester sources and the FIFO's din/wr_en pins.

Parameters:
WIDTH, 8, data width in bits.
DEPTH, 8, FIFO capacity in entries; power of 2, at least 2.
NREQ, 4, number of requesters; range 2..8.
AF_THRES, 6, almost_full asserts when level >= AF_THRES; range 1..DEPTH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
req_valid  input  NREQ  per-requester beat valid.
req_last  input  NREQ  per-requester last-beat-of-packet flag; only meaningful while valid.
req_data  input  NREQ*WIDTH  per-requester data; requester i uses bits [i*WIDTH +: WIDTH].
req_ready  output  NREQ  one-hot or zero; the beat is accepted when valid[i] && ready[i].
fifo_din  output  WIDTH  registered write data to the FIFO.
fifo_wr_en  output  1  registered write strobe to the FIFO.
fifo_rd_en  input  1  copy of the FIFO consumer's read enable (observed only).
level  output  $clog2(DEPTH)+1  entries visible in the FIFO.
almost_full  output  1  level >= AF_THRES.
full  output  1  level == DEPTH.
busy  output  1  state == LOCKED.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=NREQ-1, count=0, fifo_wr_en=0, fifo_din=0, req_ready=0, level=0, almost_full=0, full=0, busy=0.
- count tracks accepted beats, including a beat still in the output register.
  - inflight = fifo_wr_en.
  - level = count - inflight.
- space = (count < DEPTH). req_ready is forced to 0 when space is 0.
- A read is counted only when fifo_rd_en && level > 0. fifo_rd_en with level == 0 is ignored.
- Per clock: count += accepted beat (0/1), count -= counted read (0/1). An accept and a read in the same cycle leave count unchanged.
- IDLE state:
  - Combinational grant goes to the first i with req_valid[i], searching cyclically from rr_ptr+1.
  - req_ready[g] = space.
  - On accept: rr_ptr <= g, owner <= g.
  - If req_last[g]: stay in IDLE. Otherwise: go to LOCKED.
- LOCKED state:
  - req_ready[owner] = req_valid[owner] && space. All other readies are 0.
  - Bubbles from the owner are allowed.
  - An accept with req_last[owner] returns to IDLE.
  - rr_ptr is not updated in LOCKED.
- Output timing: an accept in cycle N gives fifo_wr_en=1 and fifo_din=req_data[g] in cycle N+1. With no accept, fifo_wr_en=0 in cycle N+1 and fifo_din holds its value. Back-to-back accepts give continuous writes at 1 per clock.
- Fairness: each valid requester is granted within NREQ-1 packets of other requesters.
- Full boundary:
  - At count == DEPTH, all readies are 0. The arbiter state and owner are held.
  - A counted read reopens space on the next cycle; no combinational read-to-ready path.
- Reset mid-packet: returns to IDLE with lock and count cleared. The FIFO must be reset in the same event.
- level, almost_full and full are registered: they are derived from the next-state count and inflight, and have no combinational input dependency.

Test Plan:
1. Round-robin, no lock: reset, then requesters 0..3 each valid with last=1, data 8'h10+i, continuously. Grants 0,1,2,3,0,... one per clock; fifo_din sequence 10,11,12,13 starting one cycle after the first accept; level rises 0,1,2,...
2. Packet lock: requester 1 sends 3 beats (last on the 3rd) while requester 2 is valid throughout. Requester 2 receives no ready until requester 1's last beat is accepted, then is granted the next cycle; busy=1 for exactly the 2 cycles after beat 1.
3. Full stall: DEPTH=8, no reads, single requester streams 10 beats. Exactly 8 accepts; ready=0 once count=8; full=1 and level=8 one cycle after the 8th write. Pulsing fifo_rd_en once gives exactly one more accept, one cycle after the read.
4. Simultaneous accept and read at level=5: count stays 5; almost_full (AF_THRES=6) stays 0; the next accept with no read gives level=6, almost_full=1.
5. Empty read: fifo_rd_en=1 with level=0, including the cycle when the first write is in flight. Level goes 0 to 1 with no underflow or wrap.
6. Async reset mid-packet while LOCKED: all outputs 0 immediately, without waiting for a clock edge; after release, grant starts at requester 0.

Source files
------------

// File: rtl/fifo_rr_wr_arbiter_if.sv
// Requester-side handshake bundle: per-requester valid/last/data in, one-hot ready out.
interface fifo_rr_wr_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;

  // Requester sources drive beats and observe ready
  modport master (
    output req_valid, req_last, req_data,
    input  req_ready
  );

  // Arbiter observes beats and drives ready
  modport slave (
    input  req_valid, req_last, req_data,
    output req_ready
  );
endinterface

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin, packet-locking write arbiter in front of a synchronous FIFO.
// Tracks FIFO occupancy from issued writes and observed reads; never overfills.
module fifo_rr_wr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AF_THRES = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  fifo_rr_wr_arbiter_if.slave      req,
  output logic [WIDTH-1:0]         fifo_din,
  output logic                     fifo_wr_en,
  input  logic                     fifo_rd_en,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     full,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     level_q, level_d;
  logic              wr_en_q, wr_en_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic              af_q, af_d;
  logic              full_q, full_d;

  logic [PW-1:0]     grant_c;
  logic              grant_vld_c;
  logic [PW-1:0]     sel_c;
  logic [WIDTH-1:0]  din_sel_c;
  logic              space_c;
  logic              rd_cnt_c;
  logic              accept_c;
  logic [NREQ-1:0]   ready_c;

  // Cyclic first-valid search from rr_ptr+1, selected source and its data
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_c     = '0;
    grant_vld_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!grant_vld_c && req.req_valid[PW'(idx)]) begin
        grant_c     = PW'(idx);
        grant_vld_c = 1'b1;
      end
    end
    sel_c     = (state_q == IDLE) ? grant_c : owner_q;
    din_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_c == PW'(i)) din_sel_c = req.req_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state, ready generation and occupancy bookkeeping
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    ready_c  = '0;
    space_c  = (count_q < CW'(DEPTH));
    rd_cnt_c = fifo_rd_en && (level_q != '0);

    case (state_q)
      IDLE:    if (grant_vld_c && space_c) ready_c[grant_c] = 1'b1;
      LOCKED:  if (space_c && req.req_valid[owner_q]) ready_c[owner_q] = 1'b1;
      default: ready_c = '0;
    endcase

    // Keep ready low while reset is held so every output reads zero immediately
    if (!rst) ready_c = '0;

    accept_c = |(ready_c & req.req_valid);

    if (accept_c) begin
      if (state_q == IDLE) begin
        rr_ptr_d = grant_c;
        owner_d  = grant_c;
      end
      state_d = req.req_last[sel_c] ? IDLE : LOCKED;
    end

    wr_en_d = accept_c;
    din_d   = accept_c ? din_sel_c : din_q;
    count_d = count_q + CW'(accept_c) - CW'(rd_cnt_c);
    level_d = count_d - CW'(wr_en_d);
    af_d    = (level_d >= CW'(AF_THRES));
    full_d  = (level_d == CW'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= PW'(NREQ - 1);
      owner_q  <= '0;
      count_q  <= '0;
      level_q  <= '0;
      wr_en_q  <= 1'b0;
      din_q    <= '0;
      af_q     <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
      level_q  <= level_d;
      wr_en_q  <= wr_en_d;
      din_q    <= din_d;
      af_q     <= af_d;
      full_q   <= full_d;
    end
  end

  assign req.req_ready = ready_c;
  assign fifo_din      = din_q;
  assign fifo_wr_en    = wr_en_q;
  assign level         = level_q;
  assign almost_full   = af_q;
  assign full          = full_q;
  assign busy          = (state_q == LOCKED);

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Randomized and directed bench for fifo_rr_wr_arbiter against a behavioural model.
module tb_fifo_rr_wr_arbiter;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int NREQ     = 4;
  localparam int AF_THRES = 6;

  logic             clk;
  logic             rst;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_din;
  logic             fifo_wr_en;
  logic [3:0]       level;
  logic             almost_full;
  logic             full;
  logic             busy;

  fifo_rr_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  fifo_rr_wr_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .AF_THRES(AF_THRES)
  ) dut (
    .clk(clk), .rst(rst), .req(bus),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .level(level), .almost_full(almost_full), .full(full), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: occupancy count, in-flight write, current packet owner (-1 = none), last grantee
  int               m_count, m_wr, m_owner, m_ptr;
  logic [WIDTH-1:0] m_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which requester may transfer this cycle, from the arbitration rules
  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_count >= DEPTH) return r;
    if (m_owner >= 0) begin
      if (bus.req_valid[m_owner]) r[m_owner] = 1'b1;
      return r;
    end
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (bus.req_valid[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // One clock: called just after a falling edge with inputs already driven
  task automatic step(output logic acc, output int g);
    logic [NREQ-1:0] er;
    logic            rd;
    #1;
    er = exp_ready();
    check("req_ready", 32'(bus.req_ready), 32'(er));
    acc = |(er & bus.req_valid);
    g = 0;
    for (int i = 0; i < NREQ; i++) if (er[i]) g = i;
    rd = fifo_rd_en && ((m_count - m_wr) > 0);
    @(posedge clk);
    if (acc) begin
      m_din = bus.req_data[g*WIDTH +: WIDTH];
      if (m_owner < 0) m_ptr = g;
      m_owner = bus.req_last[g] ? -1 : g;
    end
    m_count = m_count + (acc ? 1 : 0) - (rd ? 1 : 0);
    m_wr    = acc ? 1 : 0;
    #1;
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr));
    check("fifo_din", 32'(fifo_din), 32'(m_din));
    check("level", 32'(level), 32'(m_count - m_wr));
    check("almost_full", 32'(almost_full), 32'((m_count - m_wr) >= AF_THRES));
    check("full", 32'(full), 32'((m_count - m_wr) == DEPTH));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    @(negedge clk);
  endtask

  // Asynchronous reset assert with immediate output check, release on a falling edge
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    check("rst_din", 32'(fifo_din), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_af", 32'(almost_full), 32'(0));
    check("rst_full", 32'(full), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_ready", 32'(bus.req_ready), 32'(0));
    m_count = 0; m_wr = 0; m_owner = -1; m_ptr = NREQ - 1; m_din = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    fifo_rd_en    = 1'b0;
  endtask

  initial begin
    logic acc;
    int   g;
    int   beats;
    int   n_wr;
    rst = 1'b1;
    idle_inputs();
    #2;
    do_reset();

    // Round-robin with single-beat packets
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'(8'h10 + i);
    bus.req_valid = '1;
    bus.req_last  = '1;
    for (int k = 0; k < 6; k++) begin
      step(acc, g);
      check("rr_din", 32'(fifo_din), 32'(8'h10 + (k % NREQ)));
    end
    idle_inputs();
    #2; do_reset();

    // Packet lock: requester 1 sends 3 beats while requester 2 waits
    beats = 0;
    bus.req_valid = 4'b0110;
    bus.req_last  = 4'b0100;
    bus.req_data[1*WIDTH +: WIDTH] = 8'h20;
    bus.req_data[2*WIDTH +: WIDTH] = 8'h30;
    for (int k = 0; k < 5; k++) begin
      step(acc, g);
      if (k < 3) check("lock_busy", 32'(busy), 32'(k < 2));
      if (k == 3) check("lock_next", 32'(fifo_din), 32'(8'h30));
      if (acc && g == 1) begin
        beats++;
        bus.req_data[1*WIDTH +: WIDTH] = 8'(8'h20 + beats);
        bus.req_last[1] = (beats == 2);
        if (beats == 3) bus.req_valid[1] = 1'b0;
      end
      if (acc && g == 2) bus.req_valid[2] = 1'b0;
    end
    idle_inputs();
    #2; do_reset();

    // Full stall with a single streaming requester and no reads
    n_wr = 0;
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_data[7:0] = 8'h40;
    for (int k = 0; k < 12; k++) begin
      step(acc, g);
      if (fifo_wr_en) n_wr++;
      if (acc) bus.req_data[7:0] = 8'(8'h40 + n_wr + 1);
    end
    check("stall_accepts", 32'(n_wr), 32'(8));
    check("stall_full", 32'(full), 32'(1));
    check("stall_level", 32'(level), 32'(8));
    fifo_rd_en = 1'b1;
    step(acc, g);
    fifo_rd_en = 1'b0;
    n_wr = 0;
    for (int k = 0; k < 4; k++) begin
      step(acc, g);
      if (fifo_wr_en) n_wr++;
    end
    check("stall_reopen", 32'(n_wr), 32'(1));
    idle_inputs();
    #2; do_reset();

    // Simultaneous accept and read around the almost-full threshold
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_data[7:0] = 8'h50;
    for (int k = 0; k < 5; k++) step(acc, g);
    bus.req_valid = '0;
    step(acc, g);
    check("sim_level5", 32'(level), 32'(5));
    bus.req_valid = 4'b0001;
    fifo_rd_en = 1'b1;
    step(acc, g);
    fifo_rd_en = 1'b0;
    check("sim_level_rw", 32'(level), 32'(4));
    check("sim_af_rw", 32'(almost_full), 32'(0));
    step(acc, g);
    bus.req_valid = '0;
    step(acc, g);
    check("sim_level6", 32'(level), 32'(6));
    check("sim_af6", 32'(almost_full), 32'(1));
    idle_inputs();
    #2; do_reset();

    // Reads while empty, including the cycle a write is in flight
    fifo_rd_en = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b0001;
    bus.req_data[7:0] = 8'h5a;
    step(acc, g);
    check("empty_level0", 32'(level), 32'(0));
    step(acc, g);
    check("empty_level1", 32'(level), 32'(1));
    step(acc, g);
    idle_inputs();
    #2; do_reset();

    // Asynchronous reset while a packet holds the lock
    bus.req_valid = 4'b1000;
    bus.req_last  = 4'b0000;
    bus.req_data[3*WIDTH +: WIDTH] = 8'h55;
    step(acc, g);
    check("mid_busy", 32'(busy), 32'(1));
    #2; do_reset();
    for (int i = 0; i < NREQ; i++) bus.req_data[i*WIDTH +: WIDTH] = 8'(8'h60 + i);
    bus.req_valid = '1;
    bus.req_last  = '1;
    step(acc, g);
    check("post_rst_grant", 32'(fifo_din), 32'(8'h60));
    idle_inputs();
    #2; do_reset();

    // Randomized traffic with held beats, bubbles and random reads
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 9) < 3)) begin
          bus.req_valid[i] = 1'b1;
          bus.req_data[i*WIDTH +: WIDTH] = 8'($urandom);
          bus.req_last[i] = ($urandom_range(0, 2) == 0);
        end
      end
      fifo_rd_en = ($urandom_range(0, 1) == 1);
      step(acc, g);
      if (acc) begin
        bus.req_data[g*WIDTH +: WIDTH] = 8'($urandom);
        bus.req_last[g] = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 1) == 1) bus.req_valid[g] = 1'b0;
      end
      if (c == 700) begin
        #2; do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
